fetch_unit: RTL and testbench

- Program-counter and fetch stage that drives the word address into the combinational instruction memory (`inst_add` -> `inst`, 256 words, indexed by `inst_add[7:0]`).
- Registers the returned word into the IF/ID pipeline register for the decoder.
- Handles pipeline stalls, branch/jump redirects, HALT detection (opcode 6'b111111) and a retired-fetch counter.

---
 rtl/fetch_unit_pkg.sv | 22 ++
 rtl/fetch_unit_pc_reg.sv | 28 ++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the fetch stage: HALT encoding, opcode field
// location, default reset PC and the fetch FSM state type.
package fetch_unit_pkg;

    localparam int unsigned OPCODE_MSB = 31;
    localparam int unsigned OPCODE_LSB = 26;
    localparam int unsigned OPCODE_WIDTH = OPCODE_MSB - OPCODE_LSB + 1;

    localparam logic [OPCODE_WIDTH-1:0] DEFAULT_HALT_OPCODE = 6'b111111;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // Extracts the opcode field from an instruction word.
    function automatic logic [OPCODE_WIDTH-1:0] get_opcode(input logic [31:0] word);
        return word[OPCODE_MSB:OPCODE_LSB];
    endfunction

endpackage

// File: rtl/fetch_unit_pc_reg.sv
// Program counter register: asynchronous reset to RESET_PC, load of a
// redirect target, otherwise increment when asked or hold.
module pc_reg
    import fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] load_value,
    input  logic                  inc,
    output logic [ADDR_WIDTH-1:0] pc
);

    // Load wins over increment; with neither asserted the PC holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc <= RESET_PC;
        end else if (load) begin
            pc <= load_value;
        end else if (inc) begin
            pc <= pc + ADDR_WIDTH'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: presents the PC to instruction memory, captures the returned
// word into IF/ID, detects HALT and counts captured instructions.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC = ADDR_WIDTH'(DEFAULT_RESET_PC),
    parameter logic [OPCODE_WIDTH-1:0] HALT_OPCODE = DEFAULT_HALT_OPCODE
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic [ADDR_WIDTH-1:0] inst_add,
    input  logic [31:0]           inst,
    output logic [31:0]           if_id_inst,
    output logic [ADDR_WIDTH-1:0] if_id_pc,
    output logic                  if_id_valid,
    output logic                  halted,
    output logic [31:0]           fetch_count
);

    fetch_state_t state;
    fetch_state_t next_state;

    logic [ADDR_WIDTH-1:0] pc;
    logic                  is_halt;
    logic                  capture;
    logic                  pc_inc;

    assign is_halt  = (get_opcode(inst) == HALT_OPCODE);
    assign inst_add = pc;
    assign halted   = (state == HALTED);

    pc_reg #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .RESET_PC   (RESET_PC)
    ) u_pc_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (redirect_valid),
        .load_value (redirect_pc),
        .inc        (pc_inc),
        .pc         (pc)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next state and fetch controls; redirect outranks stall, stall outranks normal fetch.
    always_comb begin
        next_state = state;
        capture    = 1'b0;
        pc_inc     = 1'b0;
        unique case (state)
            RUN: begin
                if (!redirect_valid && !stall) begin
                    capture = 1'b1;
                    if (is_halt) begin
                        next_state = HALTED;
                    end else begin
                        pc_inc = 1'b1;
                    end
                end
            end
            HALTED: begin
                if (redirect_valid) begin
                    next_state = RUN;
                end
            end
            default: begin
                next_state = RUN;
            end
        endcase
    end

    // IF/ID register and fetch counter; HALT is handed on once, then valid drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_inst  <= 32'h0;
            if_id_pc    <= '0;
            if_id_valid <= 1'b0;
            fetch_count <= 32'h0;
        end else if (redirect_valid) begin
            if_id_valid <= 1'b0;
        end else if (capture) begin
            if_id_inst  <= is_halt ? {HALT_OPCODE, 26'b0} : inst;
            if_id_pc    <= pc;
            if_id_valid <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
        end else if (!stall) begin
            if_id_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations plus randomized stall/redirect traffic against a
// transaction-level model of the fetch stage.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic [31:0] inst_add;
    logic [31:0] inst;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc;
    logic        if_id_valid;
    logic        halted;
    logic [31:0] fetch_count;

    logic [31:0] mem [256];

    int compared = 0;
    int mismatched = 0;

    // Expected architectural view of the fetch stage.
    logic [31:0] m_pc = 32'h0;
    logic [31:0] m_inst = 32'h0;
    logic [31:0] m_ifpc = 32'h0;
    logic        m_valid = 1'b0;
    logic        m_halted = 1'b0;
    logic [31:0] m_count = 32'h0;

    fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_add       (inst_add),
        .inst           (inst),
        .if_id_inst     (if_id_inst),
        .if_id_pc       (if_id_pc),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .fetch_count    (fetch_count)
    );

    // Instruction memory: combinational, indexed by the low 8 address bits.
    assign inst = mem[inst_add[7:0]];

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one set of inputs for n rising edges; returns 2 time units after the last edge.
    task automatic applyStimulus(input logic st, input logic rv, input logic [31:0] rp, input int n);
        stall = st;
        redirect_valid = rv;
        redirect_pc = rp;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst inst_add", inst_add, 32'h0);
        checkOutput("rst if_id_inst", if_id_inst, 32'h0);
        checkOutput("rst if_id_pc", if_id_pc, 32'h0);
        checkOutput("rst if_id_valid", 32'(if_id_valid), 32'h0);
        checkOutput("rst halted", 32'(halted), 32'h0);
        checkOutput("rst fetch_count", fetch_count, 32'h0);
    endtask

    // Reference model: applies the per-edge priority rules directly.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            m_pc = 32'h0; m_inst = 32'h0; m_ifpc = 32'h0;
            m_valid = 1'b0; m_halted = 1'b0; m_count = 32'h0;
        end else if (redirect_valid) begin
            m_pc = redirect_pc;
            m_valid = 1'b0;
            m_halted = 1'b0;
        end else if (stall) begin
            m_valid = m_valid;
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else if (mem[m_pc[7:0]][31:26] == 6'h3F) begin
            m_inst = 32'hFC00_0000;
            m_ifpc = m_pc;
            m_valid = 1'b1;
            m_count = m_count + 1;
            m_halted = 1'b1;
        end else begin
            m_inst = mem[m_pc[7:0]];
            m_ifpc = m_pc;
            m_valid = 1'b1;
            m_count = m_count + 1;
            m_pc = m_pc + 1;
        end
    end

    // Compare DUT against the model on every falling edge.
    initial forever begin
        @(negedge clk);
        checkOutput("inst_add", inst_add, m_pc);
        checkOutput("if_id_valid", 32'(if_id_valid), 32'(m_valid));
        checkOutput("halted", 32'(halted), 32'(m_halted));
        checkOutput("fetch_count", fetch_count, m_count);
        if (m_valid) begin
            checkOutput("if_id_inst", if_id_inst, m_inst);
            checkOutput("if_id_pc", if_id_pc, m_ifpc);
        end
    end

    initial begin
        logic [31:0] w;
        logic [31:0] rp;
        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            if (w[31:26] == 6'h3F) w[31] = 1'b0;
            mem[i] = w;
        end
        mem[0] = 32'h8C03_0003;
        mem[1] = 32'h8C04_0004;
        mem[2] = 32'h8C05_0005;
        mem[3] = 32'h8C06_0002;
        mem[6] = {6'h3F, 26'h2A5_A5A5};
        for (int k = 0; k < 6; k++) begin
            w = $urandom;
            mem[$urandom_range(7, 254)] = {6'h3F, w[25:0]};
        end

        #3;
        checkResetState();
        #9;
        rst_n = 1'b1;

        // Two fetches, then a two-cycle stall at pc=2.
        applyStimulus(1'b0, 1'b0, 32'h0, 2);
        applyStimulus(1'b1, 1'b0, 32'h0, 2);
        checkOutput("stall inst_add", inst_add, 32'd2);
        checkOutput("stall if_id_pc", if_id_pc, 32'd1);
        checkOutput("stall if_id_inst", if_id_inst, 32'h8C04_0004);
        checkOutput("stall fetch_count", fetch_count, 32'd2);
        applyStimulus(1'b0, 1'b0, 32'h0, 1);
        checkOutput("resume if_id_inst", if_id_inst, 32'h8C05_0005);

        // Redirect to 5 while stalled at pc=3.
        applyStimulus(1'b1, 1'b1, 32'd5, 1);
        checkOutput("redir inst_add", inst_add, 32'd5);
        checkOutput("redir if_id_valid", 32'(if_id_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1);
        checkOutput("redir if_id_pc", if_id_pc, 32'd5);
        checkOutput("redir if_id_valid2", 32'(if_id_valid), 32'd1);

        // HALT at word 6, held once by a stall, then dropped.
        applyStimulus(1'b0, 1'b0, 32'h0, 1);
        checkOutput("halt if_id_inst", if_id_inst, 32'hFC00_0000);
        checkOutput("halt halted", 32'(halted), 32'd1);
        checkOutput("halt inst_add", inst_add, 32'd6);
        checkOutput("halt fetch_count", fetch_count, 32'd5);
        applyStimulus(1'b1, 1'b0, 32'h0, 1);
        checkOutput("halt stall valid", 32'(if_id_valid), 32'd1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1);
        checkOutput("halt drop valid", 32'(if_id_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 10);
        checkOutput("halt frozen pc", inst_add, 32'd6);
        checkOutput("halt frozen count", fetch_count, 32'd5);

        // Redirect out of HALTED to word 0.
        applyStimulus(1'b0, 1'b1, 32'h0, 1);
        checkOutput("unhalt halted", 32'(halted), 32'd0);
        applyStimulus(1'b0, 1'b0, 32'h0, 1);
        checkOutput("refetch inst", if_id_inst, 32'h8C03_0003);
        checkOutput("refetch count", fetch_count, 32'd6);

        // Asynchronous reset in the middle of a stall.
        applyStimulus(1'b1, 1'b0, 32'h0, 1);
        rst_n = 1'b0;
        #1;
        checkResetState();
        #3;
        rst_n = 1'b1;

        // Four free-running fetches from reset.
        applyStimulus(1'b0, 1'b0, 32'h0, 4);
        checkOutput("run4 if_id_inst", if_id_inst, 32'h8C06_0002);
        checkOutput("run4 if_id_pc", if_id_pc, 32'd3);
        checkOutput("run4 inst_add", inst_add, 32'd4);
        checkOutput("run4 fetch_count", fetch_count, 32'd4);

        // PC crossing 255 -> 256 aliases back to word 0.
        applyStimulus(1'b0, 1'b1, 32'd255, 1);
        applyStimulus(1'b0, 1'b0, 32'h0, 1);
        checkOutput("wrap inst_add", inst_add, 32'd256);
        applyStimulus(1'b0, 1'b0, 32'h0, 1);
        checkOutput("wrap if_id_pc", if_id_pc, 32'd256);
        checkOutput("wrap if_id_inst", if_id_inst, 32'h8C03_0003);

        // Randomized stall/redirect traffic.
        for (int n = 0; n < 1500; n++) begin
            rp = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 300)) : $urandom;
            applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 9) == 0, rp, 1);
        end

        applyStimulus(1'b0, 1'b0, 32'h0, 1);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
